// File: rtl/io_bridge_pkg.sv
// io_bridge shared definitions: address map, timer register offsets,
// CTRL field positions, MODE codes and the timer FSM state encoding.
package io_bridge_pkg;

    // Address map (inclusive limits)
    localparam logic [31:0] DM_LIMIT  = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE  = 32'h0000_7F00;
    localparam logic [31:0] TC0_LIMIT = 32'h0000_7F0B;
    localparam logic [31:0] TC1_BASE  = 32'h0000_7F10;
    localparam logic [31:0] TC1_LIMIT = 32'h0000_7F1B;
    localparam logic [31:0] EXT_BASE  = 32'h0000_7F20;
    localparam logic [31:0] EXT_LIMIT = 32'h0000_7F23;

    // Timer register word offsets (address bits [3:2])
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL field positions
    localparam int CTRL_EN = 0;
    localparam int CTRL_IM = 3;

    // MODE code that reloads; every other code behaves as one-shot
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_e;

    // Inclusive address range test
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/io_bridge_if.sv
// CPU M-stage data port bundle between the CPU (master) and io_bridge (slave).
interface io_bridge_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_rdata;

    modport master (
        output cpu_addr,
        output cpu_wdata,
        output cpu_byteen,
        input  cpu_rdata
    );

    modport slave (
        input  cpu_addr,
        input  cpu_wdata,
        input  cpu_byteen,
        output cpu_rdata
    );
endinterface

// File: rtl/io_bridge_tc_core.sv
// Count-down timer core (tc_core): CTRL/PRESET/COUNT registers, the
// IDLE/LOAD/CNT/INT sequencer and the interrupt flag. Writes arrive only as
// full-word stores already qualified by the bridge decode.
module io_bridge_tc_core
    import io_bridge_pkg::*;
#(
    parameter int TC_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel_i,      // address hits this timer's region
    input  logic        wr_i,       // full-word store this cycle
    input  logic [1:0]  off_i,      // register word offset
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    tc_state_e         state_q;
    logic [3:0]        ctrl_q;
    logic [TC_W-1:0]   preset_q;
    logic [TC_W-1:0]   count_q;
    logic              irq_q;

    logic              ctrl_wr_s;
    logic              preset_wr_s;
    logic              reload_s;
    logic              irq_set_s;
    logic              irq_clr_s;

    // Write strobes and interrupt set/clear conditions
    always_comb begin
        ctrl_wr_s   = sel_i && wr_i && (off_i == OFF_CTRL);
        preset_wr_s = sel_i && wr_i && (off_i == OFF_PRESET);
        reload_s    = (ctrl_q[2:1] == MODE_RELOAD);
        irq_set_s   = (state_q == TC_CNT) && ctrl_q[CTRL_EN] && (count_q == '0);
        irq_clr_s   = ctrl_wr_s || preset_wr_s || ((state_q == TC_INT) && reload_s);
    end

    // Timer registers, sequencer and irq flag (CPU CTRL write beats FSM EN clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= TC_IDLE;
            ctrl_q   <= 4'h0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (preset_wr_s) begin
                preset_q <= wdata_i[TC_W-1:0];
            end else begin
                preset_q <= preset_q;
            end

            if (ctrl_wr_s) begin
                ctrl_q <= wdata_i[3:0];
            end else if ((state_q == TC_INT) && !reload_s) begin
                ctrl_q[CTRL_EN] <= 1'b0;
            end else begin
                ctrl_q <= ctrl_q;
            end

            // a new expiry takes priority over a simultaneous clear
            if (irq_set_s) begin
                irq_q <= 1'b1;
            end else if (irq_clr_s) begin
                irq_q <= 1'b0;
            end else begin
                irq_q <= irq_q;
            end

            case (state_q)
                TC_IDLE: begin
                    if (ctrl_q[CTRL_EN]) begin
                        state_q <= TC_LOAD;
                    end else begin
                        state_q <= TC_IDLE;
                    end
                end
                TC_LOAD: begin
                    count_q <= preset_q;
                    state_q <= TC_CNT;
                end
                TC_CNT: begin
                    if (!ctrl_q[CTRL_EN]) begin
                        state_q <= TC_IDLE;
                    end else if (count_q == '0) begin
                        state_q <= TC_INT;
                    end else begin
                        count_q <= count_q - {{(TC_W-1){1'b0}}, 1'b1};
                    end
                end
                TC_INT: begin
                    if (reload_s) begin
                        state_q <= TC_LOAD;
                    end else begin
                        state_q <= TC_IDLE;
                    end
                end
                default: begin
                    state_q <= TC_IDLE;
                end
            endcase
        end
    end

    // Register read-back; unused CTRL bits read as zero
    always_comb begin
        rdata_o = 32'h0;
        case (off_i)
            OFF_CTRL:   rdata_o = {28'h0, ctrl_q};
            OFF_PRESET: rdata_o = 32'(preset_q);
            OFF_COUNT:  rdata_o = 32'(count_q);
            default:    rdata_o = 32'h0;
        endcase
    end

    assign irq_o = irq_q & ctrl_q[CTRL_IM];

endmodule

// File: rtl/io_bridge.sv
// io_bridge: decodes the CPU M-stage data port onto data memory, timers
// TC0/TC1 and the external-interrupt latch; returns read data combinationally
// and drives hwint[5:0] = {3'b0, ext_pend, tc1_irq, tc0_irq}.
// Build option: define IO_TC1_EN to instantiate TC1; otherwise its region
// reads 0, ignores writes and hwint[1] stays 0.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int TC_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    io_bridge_if.slave    cpu,
    output logic [31:0]   dm_addr_o,
    output logic [31:0]   dm_wdata_o,
    output logic [3:0]    dm_byteen_o,
    input  logic [31:0]   dm_rdata_i,
    input  logic          int_ext_i,
    output logic [5:0]    hwint_o
);

    logic        dm_sel_s;
    logic        tc0_sel_s;
    logic        tc1_sel_s;
    logic        ext_sel_s;
    logic        word_wr_s;
    logic        ext_clr_s;
    logic [31:0] tc0_rdata_s;
    logic [31:0] tc1_rdata_s;
    logic        tc0_irq_s;
    logic        tc1_irq_s;
    logic [31:0] rdata_s;
    logic        ext_pend_q;

    // Address decode; peripheral writes require all four byte lanes
    always_comb begin
        dm_sel_s  = (cpu.cpu_addr <= DM_LIMIT);
        tc0_sel_s = addr_in_range(cpu.cpu_addr, TC0_BASE, TC0_LIMIT);
        ext_sel_s = addr_in_range(cpu.cpu_addr, EXT_BASE, EXT_LIMIT);
        word_wr_s = (cpu.cpu_byteen == 4'hF);
        ext_clr_s = ext_sel_s && word_wr_s;
    end

    io_bridge_tc_core #(.TC_W(TC_W)) u_tc0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel_i   (tc0_sel_s),
        .wr_i    (word_wr_s),
        .off_i   (cpu.cpu_addr[3:2]),
        .wdata_i (cpu.cpu_wdata),
        .rdata_o (tc0_rdata_s),
        .irq_o   (tc0_irq_s)
    );

`ifdef IO_TC1_EN
    assign tc1_sel_s = addr_in_range(cpu.cpu_addr, TC1_BASE, TC1_LIMIT);

    io_bridge_tc_core #(.TC_W(TC_W)) u_tc1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel_i   (tc1_sel_s),
        .wr_i    (word_wr_s),
        .off_i   (cpu.cpu_addr[3:2]),
        .wdata_i (cpu.cpu_wdata),
        .rdata_o (tc1_rdata_s),
        .irq_o   (tc1_irq_s)
    );
`else
    // TC1 region behaves as unmapped space
    assign tc1_sel_s   = 1'b0;
    assign tc1_rdata_s = 32'h0;
    assign tc1_irq_s   = 1'b0;
`endif

    // External interrupt latch: a request in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_pend_q <= 1'b0;
        end else if (int_ext_i) begin
            ext_pend_q <= 1'b1;
        end else if (ext_clr_s) begin
            ext_pend_q <= 1'b0;
        end else begin
            ext_pend_q <= ext_pend_q;
        end
    end

    // Read-data mux; unmapped addresses return zero
    always_comb begin
        if (dm_sel_s) begin
            rdata_s = dm_rdata_i;
        end else if (tc0_sel_s) begin
            rdata_s = tc0_rdata_s;
        end else if (tc1_sel_s) begin
            rdata_s = tc1_rdata_s;
        end else if (ext_sel_s) begin
            rdata_s = {31'h0, ext_pend_q};
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign cpu.cpu_rdata = rdata_s;
    assign dm_addr_o     = cpu.cpu_addr;
    assign dm_wdata_o    = cpu.cpu_wdata;
    assign dm_byteen_o   = dm_sel_s ? cpu.cpu_byteen : 4'h0;
    assign hwint_o       = {3'b000, ext_pend_q, tc1_irq_s, tc0_irq_s};

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: randomized DM/decode traffic, timer
// one-shot and auto-reload runs checked against cycle formulas, EXT latch
// model, partial-store and unmapped accesses, and asynchronous reset.
module tb_io_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dm_addr_s;
    logic [31:0] dm_wdata_s;
    logic [3:0]  dm_byteen_s;
    logic [31:0] dm_rdata_s;
    logic        int_ext_s;
    logic [5:0]  hwint_s;

    int checks = 0;
    int errors = 0;

    // Reference state for TC0 registers and the EXT latch
    logic [31:0] preset_m;
    logic [31:0] ctrl_m;
    logic        ext_m;

    io_bridge_if bus_if ();

    io_bridge #(.TC_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu         (bus_if),
        .dm_addr_o   (dm_addr_s),
        .dm_wdata_o  (dm_wdata_s),
        .dm_byteen_o (dm_byteen_s),
        .dm_rdata_i  (dm_rdata_s),
        .int_ext_i   (int_ext_s),
        .hwint_o     (hwint_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.cpu_addr   = 32'h0000_5000;
        bus_if.cpu_wdata  = 32'h0;
        bus_if.cpu_byteen = 4'h0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_if.cpu_addr   = a;
        bus_if.cpu_wdata  = d;
        bus_if.cpu_byteen = be;
        tick();
        bus_idle();
    endtask

    task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus_if.cpu_addr   = a;
        bus_if.cpu_byteen = 4'h0;
        #1;
        check(tag, bus_if.cpu_rdata, exp);
        bus_idle();
    endtask

    // One-shot: irq at E0+P+3, COUNT = P-(n-2) from n=2, EN cleared afterwards
    task automatic run_oneshot(input logic [31:0] base, input int idx, input int p,
                               input logic [1:0] mode);
        logic [31:0] ctrl;
        ctrl = {28'h0, 1'b1, mode, 1'b1};
        store(base + 32'h4, 32'(p), 4'hF);
        store(base, ctrl, 4'hF);
        for (int n = 1; n <= p + 6; n++) begin
            tick();
            check("oneshot_irq", {31'h0, hwint_s[idx]}, (n >= p + 3) ? 32'h1 : 32'h0);
            if (n >= 2) begin
                load_chk("oneshot_count", base + 32'h8, (n <= p + 2) ? 32'(p - (n - 2)) : 32'h0);
            end
        end
        load_chk("oneshot_ctrl", base, ctrl & ~32'h1);
        load_chk("oneshot_preset", base + 32'h4, 32'(p));
        store(base + 32'h4, 32'(p), 4'hF);
        check("oneshot_irq_clr", {31'h0, hwint_s[idx]}, 32'h0);
        if (base == 32'h7F00) begin
            preset_m = 32'(p);
            ctrl_m   = ctrl & ~32'h1;
        end
    endtask

    // Auto-reload on TC0: period P+3, one-cycle pulse, COUNT cycles P..0
    task automatic run_reload(input int p);
        int per;
        int ph;
        per = p + 3;
        store(32'h7F04, 32'(p), 4'hF);
        store(32'h7F00, 32'hB, 4'hF);
        for (int n = 1; n <= 3 * per + 1; n++) begin
            tick();
            check("reload_irq", {31'h0, hwint_s[0]},
                  (n >= per && ((n - per) % per) == 0) ? 32'h1 : 32'h0);
            if (n >= 2) begin
                ph = (n - 2) % per;
                load_chk("reload_count", 32'h7F08, (ph <= p) ? 32'(p - ph) : 32'h0);
            end
        end
        store(32'h7F00, 32'h0, 4'hF);
        repeat (6) tick();
        check("reload_stop", {31'h0, hwint_s[0]}, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        clr;
        logic [1:0]  modes [3];
        modes[0] = 2'b00;
        modes[1] = 2'b10;
        modes[2] = 2'b11;

        rst_n      = 1'b0;
        int_ext_s  = 1'b0;
        dm_rdata_s = 32'hDEAD_BEEF;
        preset_m   = 32'h0;
        ctrl_m     = 32'h0;
        ext_m      = 1'b0;
        bus_idle();

        // Reset state
        #12;
        check("rst_hwint", {26'h0, hwint_s}, 32'h0);
        load_chk("rst_ctrl", 32'h7F00, 32'h0);
        load_chk("rst_preset", 32'h7F04, 32'h0);
        load_chk("rst_count", 32'h7F08, 32'h0);
        load_chk("rst_ext", 32'h7F20, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // DM pass-through: directed word store then random traffic
        bus_if.cpu_addr = 32'h0000_0100; bus_if.cpu_wdata = 32'h1234; bus_if.cpu_byteen = 4'hF;
        dm_rdata_s = 32'hCAFE_0100;
        #1;
        check("dm_be_word", {28'h0, dm_byteen_s}, 32'hF);
        check("dm_wdata_word", dm_wdata_s, 32'h1234);
        check("dm_rdata_word", bus_if.cpu_rdata, 32'hCAFE_0100);
        tick();
        bus_idle();
        for (int i = 0; i < 8; i++) begin
            a  = $urandom_range(32'h2FFF, 0);
            d  = $urandom;
            be = 4'($urandom_range(15, 1));
            dm_rdata_s = $urandom;
            bus_if.cpu_addr = a; bus_if.cpu_wdata = d; bus_if.cpu_byteen = be;
            #1;
            check("dm_be", {28'h0, dm_byteen_s}, {28'h0, be});
            check("dm_addr", dm_addr_s, a);
            check("dm_wdata", dm_wdata_s, d);
            check("dm_rdata", bus_if.cpu_rdata, dm_rdata_s);
            tick();
            bus_idle();
        end
        for (int i = 0; i < 6; i++) begin
            a  = $urandom_range(32'h7EFF, 32'h3000);
            be = 4'($urandom_range(15, 1));
            dm_rdata_s = $urandom | 32'h1;
            bus_if.cpu_addr = a; bus_if.cpu_byteen = be;
            #1;
            check("nondm_be", {28'h0, dm_byteen_s}, 32'h0);
            check("nondm_rdata", bus_if.cpu_rdata, 32'h0);
            tick();
            bus_idle();
        end

        // Timer TC0 auto-reload, then one-shot runs
        run_reload(3);
        run_reload(int'($urandom_range(5, 1)));
        run_oneshot(32'h7F00, 0, 5, 2'b00);
        run_oneshot(32'h7F00, 0, int'($urandom_range(8, 0)), modes[$urandom_range(2, 0)]);
        run_oneshot(32'h7F00, 0, 0, modes[$urandom_range(2, 0)]);

        // Partial stores and COUNT writes are ignored; unmapped reads return 0
        store(32'h7F04, $urandom | 32'h100, 4'($urandom_range(14, 1)));
        load_chk("partial_preset", 32'h7F04, preset_m);
        store(32'h7F08, 32'h0000_0077, 4'hF);
        load_chk("count_ro", 32'h7F08, 32'h0);
        store(32'h7F00, 32'h0000_0009, 4'h7);
        load_chk("partial_ctrl", 32'h7F00, ctrl_m);
        check("partial_ctrl_irq", {31'h0, hwint_s[0]}, 32'h0);
        dm_rdata_s = 32'hFFFF_FFFF;
        load_chk("unmapped_7f30", 32'h7F30, 32'h0);
        load_chk("unmapped_7f0c", 32'h7F0C, 32'h0);
        tick();
        load_chk("unmapped_7f24", 32'h7F24, 32'h0);
        load_chk("unmapped_hi", $urandom | 32'h8000_0000, 32'h0);

        // EXT latch: directed pulse, set-beats-clear, partial store, clear
        int_ext_s = 1'b1;
        tick();
        int_ext_s = 1'b0;
        repeat (3) tick();
        check("ext_hold", {31'h0, hwint_s[2]}, 32'h1);
        load_chk("ext_read", 32'h7F20, 32'h1);
        int_ext_s = 1'b1;
        store(32'h7F20, 32'h0, 4'hF);
        int_ext_s = 1'b0;
        check("ext_set_wins", {31'h0, hwint_s[2]}, 32'h1);
        store(32'h7F20, 32'h0, 4'h3);
        check("ext_partial", {31'h0, hwint_s[2]}, 32'h1);
        store(32'h7F20, 32'h0, 4'hF);
        check("ext_clear", {31'h0, hwint_s[2]}, 32'h0);
        load_chk("ext_read0", 32'h7F20, 32'h0);
        ext_m = 1'b0;
        for (int i = 0; i < 30; i++) begin
            int_ext_s = ($urandom_range(3, 0) == 0);
            clr       = ($urandom_range(2, 0) == 0);
            be        = ($urandom_range(1, 0) == 0) ? 4'hF : 4'($urandom_range(14, 1));
            if (clr) begin
                bus_if.cpu_addr = 32'h7F20; bus_if.cpu_wdata = $urandom; bus_if.cpu_byteen = be;
            end
            tick();
            bus_idle();
            ext_m = int_ext_s | (ext_m & ~(clr && (be == 4'hF)));
            int_ext_s = 1'b0;
            check("ext_rand", {31'h0, hwint_s[2]}, {31'h0, ext_m});
            check("hwint_hi", {29'h0, hwint_s[5:3]}, 32'h0);
        end
        store(32'h7F20, 32'h0, 4'hF);

        // TC1 region
`ifdef IO_TC1_EN
        run_oneshot(32'h7F10, 1, int'($urandom_range(6, 0)), 2'b00);
`else
        store(32'h7F10, 32'h9, 4'hF);
        store(32'h7F14, 32'h2, 4'hF);
        for (int n = 0; n < 10; n++) begin
            tick();
            check("tc1_off_irq", {31'h0, hwint_s[1]}, 32'h0);
        end
        load_chk("tc1_off_ctrl", 32'h7F10, 32'h0);
        load_chk("tc1_off_preset", 32'h7F14, 32'h0);
`endif

        // Asynchronous reset in the middle of an auto-reload count
        store(32'h7F04, 32'd20, 4'hF);
        store(32'h7F00, 32'hB, 4'hF);
        int_ext_s = 1'b1;
        tick();
        int_ext_s = 1'b0;
        repeat (4) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_hwint", {26'h0, hwint_s}, 32'h0);
        load_chk("async_rst_ctrl", 32'h7F00, 32'h0);
        load_chk("async_rst_preset", 32'h7F04, 32'h0);
        load_chk("async_rst_count", 32'h7F08, 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_hwint", {26'h0, hwint_s}, 32'h0);
        load_chk("post_rst_count", 32'h7F08, 32'h0);
        load_chk("post_rst_ext", 32'h7F20, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
